// File: rtl/lvds_ddr_tx_ctrl.sv
// Frame-level transmit controller feeding an ODDR + TLVDS_TBUF pair: warm-up, preamble, data, tail.
// Optional LVDS_TX_PARITY_EN inserts a parity pair between the last data pair and the tail.
module lvds_ddr_tx_ctrl #(
    parameter int DATA_W     = 8,
    parameter int WARMUP     = 4,
    parameter int PRE_PAIRS  = 4,
    parameter int TAIL_PAIRS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              tx_ready,
    output logic              ddr_d0,
    output logic              ddr_d1,
    output logic              oen,
    output logic              busy,
    output logic              underrun
);

    localparam int NPAIRS = DATA_W / 2;
    localparam int CMAX_A = (WARMUP > PRE_PAIRS) ? WARMUP : PRE_PAIRS;
    localparam int CMAX   = (CMAX_A > TAIL_PAIRS) ? CMAX_A : TAIL_PAIRS;
    localparam int CNT_W  = $clog2(CMAX) + 1;
    localparam int PC_W   = $clog2(NPAIRS) + 1;

    localparam logic [CNT_W-1:0] WARM_LD = CNT_W'(WARMUP - 1);
    localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'(PRE_PAIRS - 1);
    localparam logic [CNT_W-1:0] TAIL_LD = CNT_W'(TAIL_PAIRS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PC_W-1:0]  PC_LD   = PC_W'(NPAIRS - 1);
    localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARM,
        S_PRE,
        S_DATA,
`ifdef LVDS_TX_PARITY_EN
        S_PAR,
`endif
        S_TAIL
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [PC_W-1:0]   pcnt_q;
    logic [DATA_W-1:0] sh_q;
    logic              last_q;
    logic              oen_q, d0_q, d1_q, rdy_q, busy_q, unr_q;
`ifdef LVDS_TX_PARITY_EN
    logic              par_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            last_q  <= 1'b0;
            oen_q   <= 1'b1;
            d0_q    <= 1'b0;
            d1_q    <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            unr_q   <= 1'b0;
`ifdef LVDS_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            d0_q  <= 1'b0;
            d1_q  <= 1'b0;
            rdy_q <= 1'b0;
            unr_q <= 1'b0;
            // rdy_q is only set in the final PRE cycle or at a DATA word boundary,
            // and both cases take the next word (or underrun) identically.
            if (rdy_q) begin
                state_q <= S_DATA;
                if (tx_valid) begin
                    d0_q   <= tx_data[0];
                    d1_q   <= tx_data[1];
                    sh_q   <= tx_data >> 2;
                    pcnt_q <= PC_LD;
                    last_q <= tx_last;
                    rdy_q  <= (NPAIRS == 1) && !tx_last;
`ifdef LVDS_TX_PARITY_EN
                    par_q  <= par_q ^ (^tx_data);
`endif
                end else begin
                    unr_q  <= 1'b1;
                    rdy_q  <= 1'b1;
                    pcnt_q <= '0;
                    last_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        oen_q  <= 1'b1;
                        busy_q <= 1'b0;
                        if (tx_valid) begin
                            state_q <= S_WARM;
                            cnt_q   <= WARM_LD;
                            oen_q   <= 1'b0;
                            busy_q  <= 1'b1;
`ifdef LVDS_TX_PARITY_EN
                            par_q   <= 1'b0;
`endif
                        end
                    end
                    S_WARM: begin
                        if (cnt_q == '0) begin
                            state_q <= S_PRE;
                            cnt_q   <= PRE_LD;
                            d0_q    <= 1'b1;
                            rdy_q   <= (PRE_PAIRS == 1);
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                    S_PRE: begin
                        cnt_q <= cnt_q - CNT_ONE;
                        d0_q  <= 1'b1;
                        rdy_q <= (cnt_q == CNT_ONE);
                    end
                    S_DATA: begin
                        if (pcnt_q != '0) begin
                            d0_q   <= sh_q[0];
                            d1_q   <= sh_q[1];
                            sh_q   <= sh_q >> 2;
                            pcnt_q <= pcnt_q - PC_ONE;
                            rdy_q  <= (pcnt_q == PC_ONE) && !last_q;
                        end else begin
`ifdef LVDS_TX_PARITY_EN
                            state_q <= S_PAR;
                            d0_q    <= par_q;
                            d1_q    <= ~par_q;
`else
                            state_q <= S_TAIL;
                            cnt_q   <= TAIL_LD;
`endif
                        end
                    end
`ifdef LVDS_TX_PARITY_EN
                    S_PAR: begin
                        state_q <= S_TAIL;
                        cnt_q   <= TAIL_LD;
                    end
`endif
                    S_TAIL: begin
                        if (cnt_q == '0) begin
                            state_q <= S_IDLE;
                            oen_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        oen_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_ready = rdy_q;
    assign ddr_d0   = d0_q;
    assign ddr_d1   = d1_q;
    assign oen      = oen_q;
    assign busy     = busy_q;
    assign underrun = unr_q;

endmodule

// File: tb/tb_lvds_ddr_tx_ctrl.sv
// Scoreboard bench for lvds_ddr_tx_ctrl: per-edge stimulus and expected outputs are queued together.
module tb_lvds_ddr_tx_ctrl;

    localparam int WARMUP = 4;
    localparam int PRE    = 4;
    localparam int TAIL   = 2;
    localparam int NP     = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready, ddr_d0, ddr_d1, oen, busy, underrun;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic       rst;
        logic       vld;
        logic       lst;
        logic [7:0] dat;
    } stim_t;

    stim_t      stim_q[$];
    logic [5:0] exp_q[$];

    lvds_ddr_tx_ctrl #(.DATA_W(8), .WARMUP(WARMUP), .PRE_PAIRS(PRE), .TAIL_PAIRS(TAIL)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
        .tx_ready(tx_ready), .ddr_d0(ddr_d0), .ddr_d1(ddr_d1), .oen(oen), .busy(busy),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s {oen,d0,d1,rdy,busy,unr} got=%b want=%b", tag, got, want);
    endtask

    function automatic logic [5:0] ex(input logic o, input logic a, input logic b,
                                      input logic r, input logic bz, input logic u);
        return {o, a, b, r, bz, u};
    endfunction

    task automatic push(input stim_t s, input logic [5:0] e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // Expected per-edge trace of one frame derived from the documented timing.
    task automatic build_frame(input logic [7:0] w[4], input int nw, input int gap[4],
                               input bit valid_at_idle, input logic [7:0] next_w);
        stim_t idle_s;
        stim_t s;
        logic  par;
        idle_s = '{rst: 1'b0, vld: 1'b0, lst: 1'b0, dat: 8'h00};
        par = 1'b0;
        for (int k = 0; k < WARMUP; k++)
            push('{rst: 1'b0, vld: 1'b1, lst: (nw == 1), dat: w[0]}, ex(0, 0, 0, 0, 1, 0));
        for (int k = 0; k < PRE; k++)
            push('{rst: 1'b0, vld: 1'b1, lst: (nw == 1), dat: w[0]}, ex(0, 1, 0, k == PRE - 1, 1, 0));
        for (int i = 0; i < nw; i++) begin
            for (int g = 0; g < gap[i]; g++)
                push(idle_s, ex(0, 0, 0, 1, 1, 1));
            for (int j = 0; j < NP; j++) begin
                if (j == 0)
                    s = '{rst: 1'b0, vld: 1'b1, lst: (i == nw - 1), dat: w[i]};
                else if (i + 1 < nw && gap[i + 1] == 0)
                    s = '{rst: 1'b0, vld: 1'b1, lst: (i + 1 == nw - 1), dat: w[i + 1]};
                else
                    s = idle_s;
                push(s, ex(0, w[i][2 * j], w[i][2 * j + 1], (j == NP - 1) && (i != nw - 1), 1, 0));
            end
            par = par ^ (^w[i]);
        end
`ifdef LVDS_TX_PARITY_EN
        push(idle_s, ex(0, par, ~par, 0, 1, 0));
`endif
        for (int k = 0; k < TAIL; k++)
            push(idle_s, ex(0, 0, 0, 0, 1, 0));
        if (valid_at_idle)
            push('{rst: 1'b0, vld: 1'b1, lst: 1'b1, dat: next_w}, ex(1, 0, 0, 0, 0, 0));
        else
            push(idle_s, ex(1, 0, 0, 0, 0, 0));
    endtask

    task automatic push_idle(input int n, input logic r);
        for (int k = 0; k < n; k++)
            push('{rst: r, vld: 1'b0, lst: 1'b0, dat: 8'h00}, ex(1, 0, 0, 0, 0, 0));
    endtask

    task automatic run_queue(input string name);
        stim_t s;
        logic [5:0] e;
        int idx;
        idx = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst      = s.rst;
            tx_valid = s.vld;
            tx_last  = s.lst;
            tx_data  = s.dat;
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("%s_e%0d", name, idx), {oen, ddr_d0, ddr_d1, tx_ready, busy, underrun}, e);
            idx++;
        end
    endtask

    initial begin
        logic [7:0] w[4];
        int         gap[4];
        int         base;

        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;

        push_idle(2, 1'b1);
        push_idle(2, 1'b0);
        run_queue("reset");

        w = '{8'hA5, 8'h00, 8'h00, 8'h00}; gap = '{0, 0, 0, 0};
        build_frame(w, 1, gap, 1'b0, 8'h00);
        push_idle(2, 1'b0);
        run_queue("single_a5");

        w = '{8'h0F, 8'hF0, 8'h00, 8'h00}; gap = '{0, 0, 0, 0};
        build_frame(w, 2, gap, 1'b0, 8'h00);
        push_idle(1, 1'b0);
        run_queue("two_words");

        w = '{8'h3C, 8'h81, 8'h00, 8'h00}; gap = '{0, 3, 0, 0};
        build_frame(w, 2, gap, 1'b0, 8'h00);
        push_idle(1, 1'b0);
        run_queue("underrun");

        // Reset sampled at the edge after the second data pair (E10).
        base = stim_q.size();
        w = '{8'h5A, 8'h00, 8'h00, 8'h00}; gap = '{0, 0, 0, 0};
        build_frame(w, 1, gap, 1'b0, 8'h00);
        while (stim_q.size() > base + WARMUP + PRE + 2) begin
            void'(stim_q.pop_back());
            void'(exp_q.pop_back());
        end
        push_idle(1, 1'b1);
        push_idle(1, 1'b0);
        w = '{8'hC3, 8'h00, 8'h00, 8'h00};
        build_frame(w, 1, gap, 1'b0, 8'h00);
        run_queue("midreset");

        w = '{8'h96, 8'h00, 8'h00, 8'h00}; gap = '{0, 0, 0, 0};
        build_frame(w, 1, gap, 1'b1, 8'h69);
        w = '{8'h69, 8'h00, 8'h00, 8'h00};
        build_frame(w, 1, gap, 1'b0, 8'h00);
        push_idle(2, 1'b0);
        run_queue("restart");

        w = '{8'h12, 8'h34, 8'h56, 8'hE7}; gap = '{0, 1, 0, 2};
        build_frame(w, 4, gap, 1'b0, 8'h00);
        push_idle(1, 1'b0);
        run_queue("four_words");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
